// File: rtl/stage6_accumulate_pkg.sv
// ---------------------------------------------------------------------------
// stage_pkg
// Shared widths, constants and types for the convolution accumulate stage.
//   PROD_W  : width of one coefficient*pixel product
//   SUM_W   : width of the full nine-product sum (max 9*65025 = 585225)
//   PIX_W   : output pixel width
//   CNT_W   : column/row counter width
//   PIX_SAT : saturation ceiling for the output pixel
// ---------------------------------------------------------------------------
package stage_pkg;

    localparam int PROD_W = 16;
    localparam int SUM_W  = 20;
    localparam int PIX_W  = 8;
    localparam int CNT_W  = 12;
    localparam int SHF_W  = 4;

    // Pair sums need one carry bit; the two stage-B partials need three.
    localparam int PAIR_W = PROD_W + 1;
    localparam int PART_W = SUM_W - 1;
    // One extra bit so the rounding add can never wrap.
    localparam int RND_W  = SUM_W + 1;

    localparam logic [PIX_W-1:0] PIX_SAT = 8'd255;

    // Everything stage C needs, as it leaves the adder tree.
    typedef struct packed {
        logic              valid;
        logic [SHF_W-1:0]  shift;
        logic [PART_W-1:0] part0;
        logic [PART_W-1:0] part1;
    } stage_b_t;

    // Clamp a normalised value to the pixel range.
    function automatic logic [PIX_W-1:0] sat_pix(input logic [RND_W-1:0] v);
        if (v > RND_W'(PIX_SAT)) begin
            return PIX_SAT;
        end
        return v[PIX_W-1:0];
    endfunction

endpackage

// File: rtl/stage6_accumulate_adder_tree9.sv
// ---------------------------------------------------------------------------
// adder_tree9
// Two-stage registered adder tree for nine unsigned products.
//   Stage A: four pair sums (cp1+cp2, cp3+cp4, cp5+cp6, cp7+cp8), cp9 passed.
//   Stage B: part0 = A0+A1, part1 = A2+A3+cp9.
// The normalisation shift and the valid flag travel alongside the data.
// Ports:
//   clk, rst  clock, asynchronous active-low reset
//   i_valid   products and shift valid this cycle
//   i_cp      nine products, index 0 = cp1
//   i_shift   normalisation shift sampled with i_valid
//   o_b       stage B bundle (valid, shift, two partial sums)
// ---------------------------------------------------------------------------
module adder_tree9
    import stage_pkg::*;
(
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         i_valid,
    input  logic [8:0][PROD_W-1:0]       i_cp,
    input  logic [SHF_W-1:0]             i_shift,
    output stage_b_t                     o_b
);

    logic                   r_a_valid;
    logic [SHF_W-1:0]       r_a_shift;
    logic [3:0][PAIR_W-1:0] r_a_pair;
    logic [PROD_W-1:0]      r_a_cp9;
    stage_b_t               r_b;

    // Data registers load only on valid samples; bubbles just move the flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_a_valid <= 1'b0;
            r_a_shift <= '0;
            r_a_pair  <= '0;
            r_a_cp9   <= '0;
            r_b       <= '0;
        end else begin
            r_a_valid <= i_valid;
            if (i_valid) begin
                r_a_pair[0] <= {1'b0, i_cp[0]} + {1'b0, i_cp[1]};
                r_a_pair[1] <= {1'b0, i_cp[2]} + {1'b0, i_cp[3]};
                r_a_pair[2] <= {1'b0, i_cp[4]} + {1'b0, i_cp[5]};
                r_a_pair[3] <= {1'b0, i_cp[6]} + {1'b0, i_cp[7]};
                r_a_cp9     <= i_cp[8];
                r_a_shift   <= i_shift;
            end

            r_b.valid <= r_a_valid;
            if (r_a_valid) begin
                r_b.part0 <= PART_W'(r_a_pair[0]) + PART_W'(r_a_pair[1]);
                r_b.part1 <= PART_W'(r_a_pair[2]) + PART_W'(r_a_pair[3])
                           + PART_W'(r_a_cp9);
                r_b.shift <= r_a_shift;
            end
        end
    end

    assign o_b = r_b;

endmodule

// File: rtl/stage6_accumulate.sv
// ---------------------------------------------------------------------------
// stage6_accumulate
// Sums nine coefficient*pixel products, normalises with a rounded right
// shift, saturates to 8 bits and labels each output with its column/row.
// Three register stages, one sample per cycle, no stall.
// Handshake: in_valid qualifies cp1..cp9 and norm_shift in the same cycle;
// out_valid qualifies pix_out/col_cnt/row_cnt exactly three cycles later.
// There is no back-pressure.
// Ports:
//   clk, rst      clock, asynchronous active-low reset
//   in_valid      input sample valid
//   cp1..cp9      unsigned 16-bit products
//   norm_shift    right-shift amount 0..15
//   pix_out       rounded, saturated result (held while out_valid is low)
//   out_valid     pix_out valid
//   col_cnt       column of the pixel on pix_out
//   row_cnt       row of the pixel on pix_out
//   frame_done    high with the last pixel of a frame
// ---------------------------------------------------------------------------
module stage6_accumulate
    import stage_pkg::*;
#(
    parameter int IMG_W = 256,
    parameter int IMG_H = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [PROD_W-1:0] cp1,
    input  logic [PROD_W-1:0] cp2,
    input  logic [PROD_W-1:0] cp3,
    input  logic [PROD_W-1:0] cp4,
    input  logic [PROD_W-1:0] cp5,
    input  logic [PROD_W-1:0] cp6,
    input  logic [PROD_W-1:0] cp7,
    input  logic [PROD_W-1:0] cp8,
    input  logic [PROD_W-1:0] cp9,
    input  logic [SHF_W-1:0]  norm_shift,
    output logic [PIX_W-1:0]  pix_out,
    output logic              out_valid,
    output logic [CNT_W-1:0]  col_cnt,
    output logic [CNT_W-1:0]  row_cnt,
    output logic              frame_done
);

    localparam logic [CNT_W-1:0] COL_LAST = CNT_W'(IMG_W - 1);
    localparam logic [CNT_W-1:0] ROW_LAST = CNT_W'(IMG_H - 1);

    logic [8:0][PROD_W-1:0] w_cp;
    stage_b_t               w_b;
    logic [SUM_W-1:0]       w_sum;
    logic [RND_W-1:0]       w_rnd;
    logic [RND_W-1:0]       w_total;
    logic [RND_W-1:0]       w_shifted;
    logic                   w_col_last;
    logic                   w_row_last;

    logic [PIX_W-1:0]       r_pix;
    logic                   r_valid;
    logic [CNT_W-1:0]       r_col;
    logic [CNT_W-1:0]       r_row;

    assign w_cp = {cp9, cp8, cp7, cp6, cp5, cp4, cp3, cp2, cp1};

    adder_tree9 u_tree (
        .clk     (clk),
        .rst     (rst),
        .i_valid (in_valid),
        .i_cp    (w_cp),
        .i_shift (norm_shift),
        .o_b     (w_b)
    );

    assign w_sum = {1'b0, w_b.part0} + {1'b0, w_b.part1};

    // Half-LSB rounding constant: 2^(shift-1), nothing for shift 0.
    always_comb begin
        w_rnd = '0;
        if (w_b.shift != '0) begin
            w_rnd[{1'b0, w_b.shift - 4'd1}] = 1'b1;
        end
    end

    assign w_total    = {1'b0, w_sum} + w_rnd;
    assign w_shifted  = w_total >> w_b.shift;

    assign w_col_last = (r_col == COL_LAST);
    assign w_row_last = (r_row == ROW_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pix   <= '0;
            r_valid <= 1'b0;
            r_col   <= '0;
            r_row   <= '0;
        end else begin
            r_valid <= w_b.valid;
            if (w_b.valid) begin
                r_pix <= sat_pix(w_shifted);
            end

            // Counters describe the pixel now on pix_out, so they step
            // once that pixel has been presented.
            if (r_valid) begin
                if (w_col_last) begin
                    r_col <= '0;
                    r_row <= w_row_last ? '0 : r_row + 1'b1;
                end else begin
                    r_col <= r_col + 1'b1;
                end
            end
        end
    end

    assign pix_out    = r_pix;
    assign out_valid  = r_valid;
    assign col_cnt    = r_col;
    assign row_cnt    = r_row;
    assign frame_done = r_valid & w_col_last & w_row_last;

endmodule

// File: tb/tb_stage6_accumulate.sv
// ---------------------------------------------------------------------------
// tb_stage6_accumulate
// Directed bench for stage6_accumulate with a 4x2 frame. Each step drives one
// input cycle and checks the output for the sample driven two steps earlier
// (three register stages). A small arithmetic reference is used only for the
// randomised products.
// ---------------------------------------------------------------------------
module tb_stage6_accumulate;

    logic                clk;
    logic                rst;
    logic                in_valid;
    logic [8:0][15:0]    cp_bus;
    logic [3:0]          norm_shift;
    logic [7:0]          pix_out;
    logic                out_valid;
    logic [11:0]         col_cnt;
    logic [11:0]         row_cnt;
    logic                frame_done;

    int errors = 0;
    int checks = 0;

    logic [8:0] exp_q[$];
    string      tag_q[$];
    int         exp_col;
    int         exp_row;
    logic [7:0] last_pix;

    stage6_accumulate #(.IMG_W(4), .IMG_H(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .cp1        (cp_bus[0]),
        .cp2        (cp_bus[1]),
        .cp3        (cp_bus[2]),
        .cp4        (cp_bus[3]),
        .cp5        (cp_bus[4]),
        .cp6        (cp_bus[5]),
        .cp7        (cp_bus[6]),
        .cp8        (cp_bus[7]),
        .cp9        (cp_bus[8]),
        .norm_shift (norm_shift),
        .pix_out    (pix_out),
        .out_valid  (out_valid),
        .col_cnt    (col_cnt),
        .row_cnt    (row_cnt),
        .frame_done (frame_done)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [8:0][15:0] all_cp(input logic [15:0] v);
        logic [8:0][15:0] c;
        for (int j = 0; j < 9; j++) c[j] = v;
        return c;
    endfunction

    function automatic logic [8:0][15:0] one_cp(input logic [15:0] v);
        logic [8:0][15:0] c;
        c    = '0;
        c[0] = v;
        return c;
    endfunction

    // Rounded, shifted, saturated sum of nine products.
    function automatic logic [7:0] ref_pix(input logic [8:0][15:0] c, input logic [3:0] sh);
        int unsigned s;
        s = 0;
        for (int j = 0; j < 9; j++) s += 32'(c[j]);
        if (sh != 4'd0) s += (32'd1 << (sh - 4'd1));
        s = s >> sh;
        return (s > 255) ? 8'd255 : s[7:0];
    endfunction

    // Model restart: pipeline empty, counters at origin, pix_out 0.
    task automatic model_clear();
        exp_q.delete();
        tag_q.delete();
        for (int k = 0; k < 2; k++) begin
            exp_q.push_back(9'd0);
            tag_q.push_back("pre");
        end
        exp_col  = 0;
        exp_row  = 0;
        last_pix = 8'd0;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk($sformatf("%s.pix", tag),   32'(pix_out),    32'd0);
        chk($sformatf("%s.valid", tag), 32'(out_valid),  32'd0);
        chk($sformatf("%s.col", tag),   32'(col_cnt),    32'd0);
        chk($sformatf("%s.row", tag),   32'(row_cnt),    32'd0);
        chk($sformatf("%s.fdone", tag), 32'(frame_done), 32'd0);
    endtask

    // ---------------- driver + scoreboard step ----------------
    task automatic step(input logic v, input logic [8:0][15:0] c, input logic [3:0] sh,
                        input logic [7:0] ep, input string tag);
        logic [8:0] e;
        string      t;
        in_valid   = v;
        cp_bus     = c;
        norm_shift = sh;
        exp_q.push_back({v, ep});
        tag_q.push_back(tag);
        tick();
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        chk($sformatf("%s.valid", t), 32'(out_valid), 32'(e[8]));
        if (e[8]) begin
            chk($sformatf("%s.pix", t),   32'(pix_out),    32'(e[7:0]));
            chk($sformatf("%s.col", t),   32'(col_cnt),    32'(exp_col));
            chk($sformatf("%s.row", t),   32'(row_cnt),    32'(exp_row));
            chk($sformatf("%s.fdone", t), 32'(frame_done),
                (exp_col == 3 && exp_row == 1) ? 32'd1 : 32'd0);
            last_pix = e[7:0];
            if (exp_col == 3) begin
                exp_col = 0;
                exp_row = (exp_row == 1) ? 0 : exp_row + 1;
            end else begin
                exp_col = exp_col + 1;
            end
        end else begin
            chk($sformatf("%s.hold", t),  32'(pix_out),    32'(last_pix));
            chk($sformatf("%s.col", t),   32'(col_cnt),    32'(exp_col));
            chk($sformatf("%s.row", t),   32'(row_cnt),    32'(exp_row));
            chk($sformatf("%s.fdone", t), 32'(frame_done), 32'd0);
        end
    endtask

    task automatic idle(input string tag);
        step(1'b0, '0, 4'd0, 8'd0, tag);
    endtask

    task automatic do_reset(input string tag);
        rst      = 1'b0;
        in_valid = 1'b0;
        #1;
        check_reset_outputs($sformatf("%s.now", tag));
        tick();
        check_reset_outputs($sformatf("%s.hold", tag));
        tick();
        rst = 1'b1;
        model_clear();
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        logic [8:0][15:0] c;
        logic [3:0]       sh;

        rst        = 1'b0;
        in_valid   = 1'b0;
        cp_bus     = '0;
        norm_shift = 4'd0;
        model_clear();

        // Power-on reset
        tick();
        tick();
        check_reset_outputs("por");
        rst = 1'b1;

        // Single pulse: 9*0x1000 = 36864, (36864+128)>>8 = 144
        step(1'b1, all_cp(16'h1000), 4'd8, 8'd144, "pulse144");
        idle("i1");
        idle("i2");
        idle("i3");

        // Full-scale products: saturate at shift 0, 18 at shift 15
        step(1'b1, all_cp(16'hFE01), 4'd0,  8'd255, "sat_s0");
        step(1'b1, all_cp(16'hFE01), 4'd15, 8'd18,  "max_s15");
        idle("i4");

        // Rounding edges
        step(1'b1, one_cp(16'd3), 4'd1, 8'd2, "rnd_3s1");
        step(1'b1, one_cp(16'd1), 4'd1, 8'd1, "rnd_1s1");
        step(1'b1, one_cp(16'd1), 4'd2, 8'd0, "rnd_1s2");
        idle("i5");
        idle("i6");
        idle("i7");

        // Fresh frame: eight random samples, alternating shift 0/4, one bubble
        do_reset("rstA");
        for (int i = 0; i < 8; i++) begin
            if (i == 4) idle("bubble");
            sh = (i % 2 == 1) ? 4'd4 : 4'd0;
            for (int j = 0; j < 9; j++) c[j] = 16'($urandom_range(0, 65025));
            step(1'b1, c, sh, ref_pix(c, sh), $sformatf("rand%0d", i));
        end
        idle("i8");
        idle("i9");
        idle("post_frame");

        // Reset mid-frame: five pixels out, two still in the pipeline
        do_reset("rstB");
        for (int i = 0; i < 7; i++) begin
            step(1'b1, all_cp(16'(256 * (i + 1))), 4'd8, 8'(9 * (i + 1)),
                 $sformatf("mid%0d", i));
        end
        do_reset("rstC");
        idle("drop1");
        idle("drop2");
        idle("drop3");
        // (4608+128)>>8 = 18, must appear at (0,0)
        step(1'b1, all_cp(16'h0200), 4'd8, 8'd18, "restart");
        idle("i10");
        idle("i11");
        idle("i12");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
